// File: rtl/threshold_pkg.sv
// threshold_pkg: shared state encoding and constants for threshold_ctrl.
package threshold_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam logic [7:0] THR_DEFAULT = 8'd127;
  localparam int PACK_W = 8;
endpackage

// File: rtl/threshold_packer.sv
// threshold_packer: packs binary pixels LSB-first into bytes behind a valid/ready output register.
module threshold_packer
  import threshold_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              bit_last,
  input  logic              out_ready,
  output logic              can_accept,
  output logic              out_valid,
  output logic              out_last,
  output logic [PACK_W-1:0] out_data
);
  localparam int CW = $clog2(PACK_W);
  logic [PACK_W-1:0] sr, word;
  logic [CW-1:0] cnt;
  logic load;
  assign word = sr | (PACK_W'(bit_in) << cnt);
  assign load = bit_valid && (bit_last || cnt == CW'(PACK_W - 1));
  assign can_accept = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else begin
      if (clear || load) begin
        sr <= '0;
        cnt <= '0;
      end else if (bit_valid) begin
        sr <= word;
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_last <= bit_last;
        out_data <= word;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
    end
endmodule

// File: rtl/threshold_ctrl.sv
// threshold_ctrl: binarizes a frame of grayscale pixels and streams them packed 8 per byte.
// Define ADAPTIVE_THRESH_EN to derive each frame's threshold from the previous frame's (min+max)/2.
module threshold_ctrl #(
  parameter int         IMG_W       = 28,
  parameter int         IMG_H       = 28,
  parameter logic [7:0] THR_DEFAULT = threshold_pkg::THR_DEFAULT
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] thr_cfg,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       pix_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done
);
  import threshold_pkg::*;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW = $clog2(NPIX + 1);
  state_t state, state_nx;
  logic [CW-1:0] pix_cnt;
  logic [7:0] thr;
  logic go, fire, last_pix, can_accept;
  assign go = state == IDLE && start;
  assign last_pix = pix_cnt == CW'(NPIX - 1);
  assign pix_ready = state == RUN && can_accept;
  assign fire = pix_valid && pix_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb
    state_nx = go ? RUN :
               (state == RUN && fire && last_pix) ? FLUSH :
               (state == FLUSH && out_valid && out_ready && out_last) ? DONE :
               (state == DONE) ? IDLE : state;
`ifdef ADAPTIVE_THRESH_EN
  logic first;
  logic [7:0] pmin, pmax;
  logic [8:0] sum;
  assign sum = 9'(pmin) + 9'(pmax);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      first <= 1'b1;
      pmin <= 8'hFF;
      pmax <= 8'h00;
    end else if (go) begin
      first <= 1'b0;
      pmin <= 8'hFF;
      pmax <= 8'h00;
    end else if (fire) begin
      pmin <= pix_data < pmin ? pix_data : pmin;
      pmax <= pix_data > pmax ? pix_data : pmax;
    end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pix_cnt <= '0;
      thr <= THR_DEFAULT;
    end else begin
      state <= state_nx;
      if (go) pix_cnt <= '0;
      else if (fire) pix_cnt <= pix_cnt + 1'b1;
`ifdef ADAPTIVE_THRESH_EN
      // thr_cfg only seeds the first frame; later frames inherit the midpoint
      if (go && first) thr <= thr_cfg;
      else if (state == DONE) thr <= sum[8:1];
`else
      if (go) thr <= thr_cfg;
`endif
    end
  threshold_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (go),
    .bit_valid (fire),
    .bit_in    (pix_data > thr),
    .bit_last  (last_pix),
    .out_ready (out_ready),
    .can_accept(can_accept),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data)
  );
endmodule

// File: tb/tb_threshold_ctrl.sv
// tb_threshold_ctrl: randomized frames on a 28x28 and a 3x3 instance, checked against a frame-level model.
module tb_threshold_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic st[2], pv[2], pr[2], ov[2], ordy[2], ol[2], bz[2], dn[2];
  logic [7:0] tc[2], pd[2], od[2];
  int n_chk = 0, n_fail = 0;
  logic [7:0] bq[2][$];
  logic lq[2][$];
  int dcnt[2];
  logic stall[2], pol[2];
  logic [7:0] pod[2], mthr[2];
  bit first[2];

  threshold_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .thr_cfg(tc[0]), .pix_valid(pv[0]), .pix_data(pd[0]),
    .pix_ready(pr[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]), .out_last(ol[0]),
    .busy(bz[0]), .done(dn[0]));
  threshold_ctrl #(.IMG_W(3), .IMG_H(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .thr_cfg(tc[1]), .pix_valid(pv[1]), .pix_data(pd[1]),
    .pix_ready(pr[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]), .out_last(ol[1]),
    .busy(bz[1]), .done(dn[1]));

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // pixel i of a frame lands in byte i/8, bit i%8
  function automatic logic [7:0] exp_byte(input logic [7:0] px[$], input int b, input logic [7:0] thr);
    logic [7:0] r = '0;
    for (int k = 0; k < 8; k++) if (b * 8 + k < px.size()) r[k] = px[b * 8 + k] > thr;
    return r;
  endfunction

  always @(negedge clk)
    for (int u = 0; u < 2; u++)
      if (!rst_n) stall[u] = 1'b0;
      else begin
        if (stall[u]) begin
          check("hold_valid", ov[u], 1'b1);
          check("hold_data", od[u], pod[u]);
          check("hold_last", ol[u], pol[u]);
        end
        if (ov[u] && !ordy[u]) check("ready_in_stall", pr[u], 1'b0);
        if (ov[u] && ordy[u]) begin
          bq[u].push_back(od[u]);
          lq[u].push_back(ol[u]);
        end
        if (dn[u]) dcnt[u]++;
        stall[u] = ov[u] && !ordy[u];
        pod[u] = od[u];
        pol[u] = ol[u];
      end

  task automatic frame(input int u, input logic [7:0] cfg, input logic [7:0] px[$], input int rmode, input bit spur);
    int d0, nb;
    logic [7:0] thr, lo, hi;
    logic [8:0] s;
    d0 = dcnt[u];
    nb = (px.size() + 7) / 8;
    thr = cfg;
`ifdef ADAPTIVE_THRESH_EN
    if (!first[u]) thr = mthr[u];
`endif
    bq[u].delete();
    lq[u].delete();
    @(posedge clk); #1;
    tc[u] = cfg;
    st[u] = 1'b1;
    @(posedge clk); #1;
    st[u] = 1'b0;
    check("busy_run", bz[u], 1'b1);
    fork
      for (int i = 0; i < px.size(); i++) begin
        while (rmode != 0 && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        pv[u] = 1'b1;
        pd[u] = px[i];
        @(negedge clk);
        while (!pr[u]) @(negedge clk);
        @(posedge clk); #1;
        pv[u] = 1'b0;
      end
      begin
        int hold = 0;
        while (dcnt[u] == d0) begin
          if (rmode == 1) ordy[u] = 1'($urandom_range(0, 1));
          else if (rmode == 2 && bq[u].size() > 0 && hold < 10) begin
            ordy[u] = 1'b0;
            hold++;
          end else ordy[u] = 1'b1;
          @(posedge clk); #1;
        end
        ordy[u] = 1'b1;
      end
      if (spur) begin
        repeat (20) @(posedge clk);
        #1;
        tc[u] = ~cfg;
        st[u] = 1'b1;
        @(posedge clk); #1;
        st[u] = 1'b0;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("done_pulses", dcnt[u] - d0, 1);
    check("busy_idle", bz[u], 1'b0);
    check("byte_count", bq[u].size(), nb);
    for (int b = 0; b < nb && b < bq[u].size(); b++) begin
      check($sformatf("u%0d_byte%0d", u, b), bq[u][b], exp_byte(px, b, thr));
      check($sformatf("u%0d_last%0d", u, b), lq[u][b], b == nb - 1);
    end
    lo = 8'hFF;
    hi = 8'h00;
    foreach (px[i]) begin
      if (px[i] < lo) lo = px[i];
      if (px[i] > hi) hi = px[i];
    end
    s = {1'b0, lo} + {1'b0, hi};
    mthr[u] = s[8:1];
    first[u] = 1'b0;
  endtask

  task automatic rand_px(input int n, output logic [7:0] px[$]);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [7:0] px[$];
    for (int u = 0; u < 2; u++) begin
      st[u] = 0; pv[u] = 0; pd[u] = 0; tc[u] = 0; ordy[u] = 1;
      dcnt[u] = 0; stall[u] = 0; first[u] = 1; mthr[u] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_pix_ready", pr[u], 0);
      check("rst_out_valid", ov[u], 0);
      check("rst_out_last", ol[u], 0);
      check("rst_busy", bz[u], 0);
      check("rst_done", dn[u], 0);
      check("rst_out_data", od[u], 8'h00);
    end
    rst_n = 1'b1;
    px.delete();
    for (int i = 0; i < 784; i++) px.push_back(i % 2 == 0 ? 8'd128 : 8'd127);
    frame(0, 8'd127, px, 0, 0);
    px.delete();
    repeat (9) px.push_back(8'd200);
    frame(1, 8'd127, px, 0, 0);
    px.delete();
    px.push_back(8'd20); px.push_back(8'd220);
    for (int i = 0; i < 7; i++) px.push_back(8'($urandom_range(20, 220)));
    frame(1, 8'd50, px, 1, 0);
    px.delete();
    px.push_back(8'd121); px.push_back(8'd120);
    for (int i = 0; i < 7; i++) px.push_back(8'($urandom_range(0, 255)));
    frame(1, 8'd5, px, 1, 0);
    rand_px(784, px);
    frame(0, 8'($urandom_range(0, 255)), px, 2, 0);
    rand_px(784, px);
    frame(0, 8'($urandom_range(0, 255)), px, 1, 1);
    repeat (6) begin
      rand_px(9, px);
      frame(1, 8'($urandom_range(0, 255)), px, 1, 0);
    end
    @(posedge clk); #1;
    tc[0] = 8'd127;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    for (int i = 0; i < 13; i++) begin
      pv[0] = 1'b1;
      pd[0] = 8'($urandom_range(0, 255));
      @(negedge clk);
      while (!pr[0]) @(negedge clk);
      @(posedge clk); #1;
    end
    pv[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pix_ready", pr[0], 0);
    check("midrst_out_valid", ov[0], 0);
    check("midrst_out_last", ol[0], 0);
    check("midrst_busy", bz[0], 0);
    check("midrst_done", dn[0], 0);
    check("midrst_out_data", od[0], 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    first[0] = 1;
    first[1] = 1;
    rand_px(784, px);
    frame(0, 8'($urandom_range(0, 255)), px, 1, 0);
    rand_px(9, px);
    frame(1, 8'($urandom_range(0, 255)), px, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/threshold_ctrl.md
THRESHOLD_CTRL -- requirements
Module: threshold_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 28, pixels per row.
REQ-002 SHALL have parameter IMG_H, default 28, rows per frame.
REQ-003 SHALL have parameter THR_DEFAULT, default 8'd127, threshold after reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begin one frame.
REQ-007 SHALL have port thr_cfg, input, 8 bits: static threshold, latched at start.
REQ-008 SHALL have port pix_valid, input, 1 bit: pixel available.
REQ-009 SHALL have port pix_data, input, 8 bits: grayscale pixel.
REQ-010 SHALL have port pix_ready, output, 1 bit: pixel accepted when high with pix_valid.
REQ-011 SHALL have port out_valid, output, 1 bit: packed byte available.
REQ-012 SHALL have port out_data, output, 8 bits: 8 binary pixels, bit0 = earliest pixel.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts byte.
REQ-014 SHALL have port out_last, output, 1 bit: final byte of frame, qualified by out_valid.
REQ-015 SHALL have port busy, output, 1 bit: frame in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-017 SHALL implement states IDLE, RUN, FLUSH and DONE.
REQ-018 IDLE -> RUN on start: latch the active threshold and clear the pixel counter and bit counter.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 Per accepted pixel: binary bit = (pix_data > active threshold), unsigned, strictly greater.
REQ-021 Pixel transfer SHALL occur only when pix_valid && pix_ready.
REQ-022 pix_ready SHALL be high only in RUN and when the output register is empty or being drained (out_ready high) in the same cycle.
REQ-023 On the 8th bit, or on the last pixel of the frame, the byte SHALL load the output register; out_valid SHALL rise the next cycle.
REQ-024 A partial final byte SHALL be zero-padded in its upper bits; total bytes per frame = ceil(IMG_W*IMG_H/8).
REQ-025 Packing SHALL be continuous across row boundaries.
REQ-026 After the last pixel is accepted: RUN -> FLUSH; out_last SHALL be high with the final byte.
REQ-027 FLUSH -> DONE on the final byte handshake; DONE SHALL pulse done for one cycle, then -> IDLE.
REQ-028 out_valid/out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-029 busy SHALL be high in RUN, FLUSH and DONE.
REQ-030 Pixel counter SHALL be $clog2(IMG_W*IMG_H+1) bits wide and SHALL NOT wrap within a frame.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE and clear all counters.
REQ-032 rst_n low SHALL drive pix_ready, out_valid, out_last, busy and done to 0, and out_data to 8'h00.
REQ-033 rst_n low SHALL set the stored threshold to THR_DEFAULT.
REQ-034 Reset mid-frame SHALL discard the partial byte and any pending output byte.

Configuration
REQ-035 Macro ADAPTIVE_THRESH_EN, when defined: track min and max pixel per frame; at DONE, store (min+max)>>1 (9-bit sum) as the threshold for the next start, with thr_cfg ignored except for the first frame after reset.
REQ-036 Without ADAPTIVE_THRESH_EN: threshold = thr_cfg latched at each start, and no min/max logic.

Structure
REQ-037 A shared package threshold_pkg SHALL hold the state enum, THR_DEFAULT and the byte-packing width constant (8).
REQ-038 Sub-module threshold_packer (bit shift register, bit counter, output register with valid/ready) SHALL be instantiated once.

Verification
REQ-039 Default params, thr_cfg=127, pixels alternating 128/127, out_ready=1 -> 98 bytes of 8'h55, out_last on byte 98, one done pulse.
REQ-040 IMG_W=3, IMG_H=3, all pixels 200 -> bytes 8'hFF then 8'h01 with out_last.
REQ-041 out_ready held low 10 cycles after first byte -> pix_ready low, out_data stable, no pixel lost.
REQ-042 rst_n asserted after 13 pixels -> outputs zero immediately; the next frame starts clean, with bit0 = its first pixel.
REQ-043 ADAPTIVE_THRESH_EN, frame 1 pixels span 20..220 -> frame 2 threshold 120; pixel 121 -> 1, pixel 120 -> 0.
REQ-044 start pulsed during RUN -> ignored; byte count unchanged.
